tiny_lsu: RTL and testbench

TINY_LSU -- requirements
Module: tiny_lsu

---
 rtl/tiny_lsu.sv | 207 ++++++++++++++++++++
 tb/tb_tiny_lsu.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_lsu.sv
// Single-outstanding load/store unit: aligns core requests onto a 32-bit word bus,
// extracts/extends load data and aborts bus cycles that exceed a wait budget.
module tiny_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [31:0] lane_wdata;
    logic [3:0]  store_strb;

    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'd0:    is_illegal = 1'b0;
            2'd1:    is_illegal = lo[0];
            2'd2:    is_illegal = (lo != 2'b00);
            default: is_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] extract_load(input logic [1:0] size, input logic sgn,
                                                 input logic [1:0] lo, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'h00;
        h = 16'h0000;
        case (lo)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'd0:    extract_load = {{24{sgn & b[7]}}, b};
            2'd1:    extract_load = {{16{sgn & h[15]}}, h};
            default: extract_load = rd;
        endcase
    endfunction

    // Each byte lane picks its source byte: replicated for byte/halfword, direct for word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_comb begin
                case (size_q)
                    2'd0:    lane_wdata[8*gi +: 8] = wdata_q[7:0];
                    2'd1:    lane_wdata[8*gi +: 8] = wdata_q[8*(gi%2) +: 8];
                    default: lane_wdata[8*gi +: 8] = wdata_q[8*gi +: 8];
                endcase
            end
        end
    endgenerate

    always_comb begin
        case (size_q)
            2'd0:    store_strb = 4'b0001 << addr_q[1:0];
            2'd1:    store_strb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: store_strb = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            fault_q  <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = 32'h0;
                    cnt_d    = 8'd0;
                    if (is_illegal(req_size, req_addr[1:0])) begin
                        fault_d = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        fault_d = 1'b0;
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // Ready on the final budgeted cycle still wins over the timeout.
                if (mem_ready) begin
                    rdata_d = we_q ? 32'h0 : extract_load(size_q, signed_q, addr_q[1:0], mem_rdata);
                    fault_d = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == TIMEOUT_LIMIT) begin
                        rdata_d = 32'h0;
                        fault_d = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_fault = 1'b0;
        resp_rdata = 32'h0;
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_wstrb  = 4'b0000;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
            end
            S_BUS: begin
                mem_valid = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wdata = we_q ? lane_wdata : 32'h0;
                mem_wstrb = we_q ? store_strb : 4'b0000;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_fault = fault_q;
                resp_rdata = rdata_q;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tiny_lsu.sv
// Randomized and directed bench for tiny_lsu against a byte-array memory model
// and arithmetic models of strobes, lane replication and load extension.
module tb_tiny_lsu;

    localparam int TO = 16;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [1024];

    tiny_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_strb(input logic [1:0] size, input logic [31:0] addr);
        int nb;
        nb = 1 << size;
        return 4'(((1 << nb) - 1) << addr[1:0]);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] addr);
        int base;
        base = int'(addr[9:2]) * 4;
        return {mem[base+3], mem[base+2], mem[base+1], mem[base]};
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input bit sgn,
                                           input logic [31:0] addr, input logic [31:0] word);
        longint v, mask;
        int bits;
        bits = 8 << size;
        if (bits >= 32) return word;
        mask = (longint'(1) << bits) - 1;
        v = (longint'(word) >> (8 * int'(addr[1:0]))) & mask;
        if (sgn && ((v >> (bits - 1)) & 1) == 1) v = v | (~mask);
        return 32'(v);
    endfunction

    task automatic access(input bit we, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int rdy_delay, output logic [31:0] got);
        int nb, cyc, base;
        bit legal, done, flt;
        logic [3:0] strb;
        logic [31:0] wexp, rexp;
        nb    = 1 << size;
        legal = (size != 2'd3) && ((addr % nb) == 0);
        strb  = m_strb(size, addr);
        wexp  = m_wdata(size, wdata);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        if (!legal) begin
            chk("illegal_no_bus", 32'(mem_valid), 32'd0);
            chk("illegal_resp_valid", 32'(resp_valid), 32'd1);
            chk("illegal_fault", 32'(resp_fault), 32'd1);
            chk("illegal_rdata", resp_rdata, 32'h0);
            got = resp_rdata;
            $display("txn we=%0d size=%0d addr=%08h -> fault (illegal)", we, size, addr);
            @(negedge clk);
            chk("illegal_pulse_end", 32'(resp_valid), 32'd0);
            chk("illegal_no_bus2", 32'(mem_valid), 32'd0);
            return;
        end
        cyc  = 0;
        done = 1'b0;
        flt  = 1'b0;
        while (!done && !flt) begin
            chk("bus_valid", 32'(mem_valid), 32'd1);
            chk("bus_addr", mem_addr, {addr[31:2], 2'b00});
            chk("bus_we", 32'(mem_we), 32'(we));
            chk("bus_strb", 32'(mem_wstrb), we ? 32'(strb) : 32'd0);
            if (we) chk("bus_wdata", mem_wdata, wexp);
            chk("bus_no_resp", 32'(resp_valid), 32'd0);
            mem_ready = (rdy_delay >= 0) && (cyc >= rdy_delay);
            mem_rdata = rd_word(addr);
            @(negedge clk);
            if (mem_ready) done = 1'b1;
            else begin
                cyc++;
                if (cyc == TO) flt = 1'b1;
            end
        end
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;
        if (flt) begin
            rexp = 32'h0;
        end else if (we) begin
            rexp = 32'h0;
            base = int'(addr[9:2]) * 4;
            for (int i = 0; i < 4; i++)
                if (strb[i]) mem[base+i] = wexp[8*i +: 8];
        end else begin
            rexp = m_load(size, sgn, addr, rd_word(addr));
        end
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_bus_idle", 32'(mem_valid), 32'd0);
        chk("resp_fault", 32'(resp_fault), 32'(flt));
        chk("resp_rdata", resp_rdata, rexp);
        got = resp_rdata;
        $display("txn we=%0d size=%0d sgn=%0d addr=%08h wait=%0d fault=%0d rdata=%08h",
                 we, size, sgn, addr, cyc, resp_fault, resp_rdata);
        @(negedge clk);
        chk("resp_pulse_end", 32'(resp_valid), 32'd0);
        chk("ready_after_resp", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [1:0]  sz;
        int          r, dly;

        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 32'h0000_0040;
        req_wdata  = 32'hDEAD_BEEF;
        mem_ready  = 1'b1;
        mem_rdata  = 32'h1234_5678;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_fault", 32'(resp_fault), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        req_valid = 1'b0;
        rst       = 1'b0;

        // Directed: byte store, halfword/byte loads with sign handling, misaligned word
        access(1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00A5, 0, got);
        chk("sb_rdata", got, 32'h0);
        access(1'b1, 2'd2, 1'b0, 32'h0000_0200, 32'h8001_7FFF, 0, got);
        access(1'b0, 2'd1, 1'b1, 32'h0000_0202, 32'h0, 0, got);
        chk("lh_signed", got, 32'hFFFF_8001);
        access(1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0, 0, got);
        chk("lh_unsigned", got, 32'h0000_8001);
        access(1'b0, 2'd0, 1'b1, 32'h0000_0200, 32'h0, 0, got);
        chk("lb_signed", got, 32'hFFFF_FFFF);
        access(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 0, got);
        chk("misaligned_rdata", got, 32'h0);

        // Wait states and timeout boundary
        access(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, 5, got);
        chk("wait5_rdata", got, 32'h8001_7FFF);
        access(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, TO - 1, got);
        chk("ready_at_limit", got, 32'h8001_7FFF);
        access(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, TO, got);
        access(1'b1, 2'd2, 1'b0, 32'h0000_0204, 32'h1111_2222, -1, got);

        // Reset in the middle of a bus cycle
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h0000_0300;
        req_wdata = 32'hCAFE_F00D;
        mem_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_bus_started", 32'(mem_valid), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_mem_valid_async", 32'(mem_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("abort_after_no_resp", 32'(resp_valid), 32'd0);
        chk("abort_after_no_bus", 32'(mem_valid), 32'd0);
        $display("txn reset abort during store at 00000300");
        access(1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'h0BAD_CAFE, 1, got);
        access(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0, 0, got);
        chk("post_abort_load", got, 32'h0BAD_CAFE);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~(32'((1 << sz) - 1));
            r = $urandom_range(0, 9);
            if (r < 7)       dly = r % 3;
            else if (r == 7) dly = TO - 1;
            else if (r == 8) dly = TO;
            else             dly = -1;
            access(1'($urandom), sz, 1'($urandom), a, $urandom, dly, got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
